// File: rtl/aes_req_sched_pkg.sv
// Shared types and widths for the AES request scheduler and its core-side interface.
package aes_ctrl_pkg;

    localparam int KEY_W   = 256;
    localparam int BLOCK_W = 128;

    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_INIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/aes_req_sched_if.sv
// Bundle of the signals running between the scheduler and the shared aes_core.
interface aes_req_sched_if;
    import aes_ctrl_pkg::*;

    logic               core_reset_n;
    logic               core_init;
    logic               core_next;
    logic               core_encdec;
    logic               core_keylen;
    logic [KEY_W-1:0]   core_key;
    logic [BLOCK_W-1:0] core_block;
    logic               core_ready;
    logic [BLOCK_W-1:0] core_result;
    logic               core_result_valid;

    modport master (
        output core_reset_n, core_init, core_next, core_encdec, core_keylen,
               core_key, core_block,
        input  core_ready, core_result, core_result_valid
    );

    modport slave (
        input  core_reset_n, core_init, core_next, core_encdec, core_keylen,
               core_key, core_block,
        output core_ready, core_result, core_result_valid
    );

endinterface

// File: rtl/aes_req_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan below ptr first and at/after ptr second so the wrap-around winner overrides; lowest index wins within each pass.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k] && (k < int'(ptr))) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = k[IDX_W-1:0];
                any      = 1'b1;
            end
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k] && (k >= int'(ptr))) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = k[IDX_W-1:0];
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_req_sched.sv
// Shares one aes_core between N_REQ requesters, caching the last expanded key to skip redundant key expansion.
import aes_ctrl_pkg::*;

module aes_req_sched #(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_encdec,
    input  logic [N_REQ-1:0]         req_keylen,
    input  logic [N_REQ*KEY_W-1:0]   req_key,
    input  logic [N_REQ*BLOCK_W-1:0] req_block,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [BLOCK_W-1:0]       rsp_result,
    input  logic                     key_flush,
    output logic                     busy,
    output logic [CNT_W-1:0]         init_count,
    aes_req_sched_if.master          core
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic               key_valid;
    logic               flush_pend;
    logic               hit;
    logic               encdec_reg;
    logic               keylen_reg;
    logic [KEY_W-1:0]   key_reg;
    logic [BLOCK_W-1:0] block_reg;

    logic [N_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               flush_now;
    logic               hit_now;
    logic [KEY_W-1:0]   win_key;
    logic [BLOCK_W-1:0] win_block;
    logic               win_encdec;
    logic               win_keylen;

    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Winner's fields and the key-cache hit test, which treats a pending or current flush as a miss.
    always_comb begin
        flush_now  = flush_pend | key_flush;
        win_key    = req_key[int'(arb_idx)*KEY_W +: KEY_W];
        win_block  = req_block[int'(arb_idx)*BLOCK_W +: BLOCK_W];
        win_encdec = req_encdec[arb_idx];
        win_keylen = req_keylen[arb_idx];
        hit_now    = key_valid & ~flush_now & (win_key == key_reg) & (win_keylen == keylen_reg);
    end

    // Grant, response and core pulses are decoded from the state; all are forced quiet while reset is held.
    always_comb begin
        req_ready      = '0;
        rsp_valid      = '0;
        core.core_init = 1'b0;
        core.core_next = 1'b0;
        if (!reset) begin
            if (state == S_IDLE) begin
                req_ready = arb_grant;
            end
            if (state == S_RESP) begin
                rsp_valid[owner] = 1'b1;
            end
            if (state == S_ISSUE) begin
                core.core_init = ~hit;
                core.core_next = hit;
            end
        end
    end

    assign busy              = (state != S_IDLE);
    assign core.core_reset_n = ~reset;
    assign core.core_encdec  = encdec_reg;
    assign core.core_keylen  = keylen_reg;
    assign core.core_key     = key_reg;
    assign core.core_block   = block_reg;

    // Main sequencer: arbitrate, issue init/next, wait on the core, then hold the result until the owner takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            key_valid  <= 1'b0;
            flush_pend <= 1'b0;
            hit        <= 1'b0;
            encdec_reg <= 1'b0;
            keylen_reg <= KEYLEN_128;
            key_reg    <= '0;
            block_reg  <= '0;
            rsp_result <= '0;
            init_count <= '0;
        end else begin
            if ((state != S_IDLE) && key_flush) begin
                flush_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (flush_now) begin
                        key_valid  <= 1'b0;
                        flush_pend <= 1'b0;
                    end
                    if (arb_any) begin
                        encdec_reg <= win_encdec;
                        keylen_reg <= win_keylen;
                        key_reg    <= win_key;
                        block_reg  <= win_block;
                        owner      <= arb_idx;
                        hit        <= hit_now;
                        key_valid  <= hit_now;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (hit) begin
                        state <= S_NEXT;
                    end else begin
                        if (init_count != {CNT_W{1'b1}}) begin
                            init_count <= init_count + CNT_W'(1);
                        end
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (core.core_ready) begin
                        key_valid <= 1'b1;
                        hit       <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_NEXT: begin
                    if (core.core_ready && core.core_result_valid) begin
                        rsp_result <= core.core_result;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        rr_ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_sched.sv
// Directed bench for aes_req_sched with a behavioural aes_core stand-in that remembers the key given at init.
module tb_aes_req_sched;

    localparam int N_REQ    = 2;
    localparam int CNT_W    = 16;
    localparam int INIT_LAT = 6;
    localparam int NEXT_LAT = 8;

    localparam logic [255:0] KEY_A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_B = {128'hffeeddccbbaa99887766554433221100, 128'h0};
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                 clk;
    logic                 reset;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     req_encdec;
    logic [N_REQ-1:0]     req_keylen;
    logic [N_REQ*256-1:0] req_key;
    logic [N_REQ*128-1:0] req_block;
    logic [N_REQ-1:0]     rsp_valid;
    logic [N_REQ-1:0]     rsp_ready;
    logic [127:0]         rsp_result;
    logic                 key_flush;
    logic                 busy;
    logic [CNT_W-1:0]     init_count;

    aes_req_sched_if core_if ();

    aes_req_sched #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_encdec (req_encdec),
        .req_keylen (req_keylen),
        .req_key    (req_key),
        .req_block  (req_block),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .key_flush  (key_flush),
        .busy       (busy),
        .init_count (init_count),
        .core       (core_if)
    );

    int checks;
    int failures;
    int init_pulses;
    int next_pulses;
    int grant_cnt [N_REQ];
    int grant_q [$];
    int n;
    int q0;
    int i0;
    int gv;
    logic [127:0] res;
    logic ok_valid, ok_res, ok_busy, ok_ready;

    logic [255:0] m_key;
    logic         m_keylen;
    logic         m_encdec;
    logic [127:0] m_block;
    logic         m_is_next;
    int           m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in cipher: the FIPS-197 vector pair for KEY_A, otherwise a simple keyed mix.
    function automatic logic [127:0] aesModel(input logic [255:0] k, input logic kl,
                                              input logic ed, input logic [127:0] b);
        if (k == KEY_A && kl == 1'b0 && ed && b == PT) return CT;
        if (k == KEY_A && kl == 1'b0 && !ed && b == CT) return PT;
        return b ^ k[255:128] ^ k[127:0] ^ {127'd0, ed};
    endfunction

    // Core stand-in: init stores the key, next uses that stored key; ready drops the cycle after a pulse.
    always @(posedge clk) begin
        if (core_if.core_reset_n !== 1'b1) begin
            core_if.core_ready        <= 1'b1;
            core_if.core_result_valid <= 1'b0;
            core_if.core_result       <= '0;
            m_cnt                     <= 0;
            m_key                     <= '0;
            m_keylen                  <= 1'b0;
            m_is_next                 <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                core_if.core_ready <= 1'b1;
                if (m_is_next) begin
                    core_if.core_result_valid <= 1'b1;
                    core_if.core_result       <= aesModel(m_key, m_keylen, m_encdec, m_block);
                end
            end
        end else if (core_if.core_init) begin
            core_if.core_ready        <= 1'b0;
            core_if.core_result_valid <= 1'b0;
            m_cnt                     <= INIT_LAT;
            m_key                     <= core_if.core_key;
            m_keylen                  <= core_if.core_keylen;
            m_is_next                 <= 1'b0;
        end else if (core_if.core_next) begin
            core_if.core_ready        <= 1'b0;
            core_if.core_result_valid <= 1'b0;
            m_cnt                     <= NEXT_LAT;
            m_encdec                  <= core_if.core_encdec;
            m_block                   <= core_if.core_block;
            m_is_next                 <= 1'b1;
        end
    end

    // Counts core pulses and records every accepted grant in order.
    always @(posedge clk) begin
        if (core_if.core_init === 1'b1) init_pulses <= init_pulses + 1;
        if (core_if.core_next === 1'b1) next_pulses <= next_pulses + 1;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i] === 1'b1) begin
                grant_cnt[i] <= grant_cnt[i] + 1;
                grant_q.push_back(i);
            end
        end
    end

    // Hard time limit so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int r, input logic ed, input logic kl,
                                 input logic [255:0] k, input logic [127:0] b);
        int g0;
        int cnt;
        g0 = grant_cnt[r];
        cnt = 0;
        req_encdec[r]          = ed;
        req_keylen[r]          = kl;
        req_key[r*256 +: 256]  = k;
        req_block[r*128 +: 128] = b;
        req_valid[r]           = 1'b1;
        while (grant_cnt[r] == g0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        req_valid[r] = 1'b0;
        checkOutput($sformatf("grant_seen_r%0d", r), 256'(grant_cnt[r] != g0), 256'd1);
    endtask

    task automatic waitRsp(input int r, output logic [127:0] result);
        int cnt;
        cnt = 0;
        while (rsp_valid[r] !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput($sformatf("rsp_seen_r%0d", r), 256'(rsp_valid[r]), 256'd1);
        result = rsp_result;
        rsp_ready[r] = 1'b1;
        @(negedge clk);
        rsp_ready[r] = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; init_pulses = 0; next_pulses = 0;
        for (int i = 0; i < N_REQ; i++) grant_cnt[i] = 0;
        reset = 1'b1; req_valid = '0; req_encdec = '0; req_keylen = '0;
        req_key = '0; req_block = '0; rsp_ready = '0; key_flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        checkOutput("rst_req_ready", 256'(req_ready), 256'd0);
        checkOutput("rst_rsp_valid", 256'(rsp_valid), 256'd0);
        checkOutput("rst_rsp_result", 256'(rsp_result), 256'd0);
        checkOutput("rst_core_init", 256'(core_if.core_init), 256'd0);
        checkOutput("rst_core_next", 256'(core_if.core_next), 256'd0);
        checkOutput("rst_busy", 256'(busy), 256'd0);
        checkOutput("rst_init_count", 256'(init_count), 256'd0);

        // key miss then key hit from the other requester
        applyStimulus(0, 1'b1, 1'b0, KEY_A, PT);
        waitRsp(0, res);
        checkOutput("miss_result", 256'(res), 256'(CT));
        checkOutput("miss_init_count", 256'(init_count), 256'd1);
        checkOutput("miss_init_pulses", 256'(init_pulses), 256'd1);
        checkOutput("miss_next_pulses", 256'(next_pulses), 256'd1);
        applyStimulus(1, 1'b1, 1'b0, KEY_A, PT);
        waitRsp(1, res);
        checkOutput("hit_result", 256'(res), 256'(CT));
        checkOutput("hit_init_count", 256'(init_count), 256'd1);
        checkOutput("hit_init_pulses", 256'(init_pulses), 256'd1);
        checkOutput("hit_next_pulses", 256'(next_pulses), 256'd2);

        // round-robin with both requesters continuously valid
        q0 = grant_q.size();
        for (int r = 0; r < N_REQ; r++) begin
            req_encdec[r] = 1'b1; req_keylen[r] = 1'b0;
            req_key[r*256 +: 256] = KEY_A; req_block[r*128 +: 128] = PT;
        end
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        n = 0;
        while (grant_q.size() < q0 + 6 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        req_valid = 2'b00;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        rsp_ready = 2'b00;
        @(negedge clk);
        checkOutput("rr_grant_count", 256'(grant_q.size() - q0), 256'd6);
        for (int k = 0; k < 6; k++) begin
            gv = (q0 + k < grant_q.size()) ? grant_q[q0 + k] : -1;
            checkOutput($sformatf("rr_grant%0d", k), 256'(gv), 256'(k % 2));
        end
        checkOutput("rr_init_count", 256'(init_count), 256'd1);

        // decrypt on requester 1
        applyStimulus(1, 1'b0, 1'b0, KEY_A, CT);
        waitRsp(1, res);
        checkOutput("dec_result", 256'(res), 256'(PT));
        checkOutput("dec_init_count", 256'(init_count), 256'd1);

        // response backpressure with a competing request pending
        applyStimulus(0, 1'b1, 1'b0, KEY_A, PT);
        req_encdec[1] = 1'b1; req_keylen[1] = 1'b0;
        req_key[256 +: 256] = KEY_A; req_block[128 +: 128] = PT;
        req_valid[1] = 1'b1;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok_valid = 1'b1; ok_res = 1'b1; ok_busy = 1'b1; ok_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid !== 2'b01) ok_valid = 1'b0;
            if (rsp_result !== CT) ok_res = 1'b0;
            if (busy !== 1'b1) ok_busy = 1'b0;
            if (req_ready !== 2'b00) ok_ready = 1'b0;
            @(negedge clk);
        end
        checkOutput("bp_rsp_valid_stable", 256'(ok_valid), 256'd1);
        checkOutput("bp_rsp_result_stable", 256'(ok_res), 256'd1);
        checkOutput("bp_busy_high", 256'(ok_busy), 256'd1);
        checkOutput("bp_no_grant", 256'(ok_ready), 256'd1);
        req_valid[1] = 1'b0;
        waitRsp(0, res);
        checkOutput("bp_result", 256'(res), 256'(CT));

        // key_flush while the core is enciphering
        i0 = init_pulses;
        applyStimulus(0, 1'b1, 1'b0, KEY_A, PT);
        n = 0;
        while (core_if.core_next !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        key_flush = 1'b1;
        @(negedge clk);
        key_flush = 1'b0;
        waitRsp(0, res);
        checkOutput("flush_cur_result", 256'(res), 256'(CT));
        checkOutput("flush_cur_no_init", 256'(init_pulses - i0), 256'd0);
        applyStimulus(1, 1'b1, 1'b0, KEY_A, PT);
        waitRsp(1, res);
        checkOutput("flush_next_result", 256'(res), 256'(CT));
        checkOutput("flush_next_init_count", 256'(init_count), 256'd2);
        checkOutput("flush_next_init_pulse", 256'(init_pulses - i0), 256'd1);

        // reset while key expansion is in progress
        applyStimulus(0, 1'b1, 1'b0, KEY_B, PT);
        n = 0;
        while (core_if.core_init !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("mid_in_init", 256'(dut.state), 256'(aes_ctrl_pkg::S_INIT));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_req_ready", 256'(req_ready), 256'd0);
        checkOutput("mid_rsp_valid", 256'(rsp_valid), 256'd0);
        checkOutput("mid_rsp_result", 256'(rsp_result), 256'd0);
        checkOutput("mid_core_init", 256'(core_if.core_init), 256'd0);
        checkOutput("mid_core_next", 256'(core_if.core_next), 256'd0);
        checkOutput("mid_busy", 256'(busy), 256'd0);
        checkOutput("mid_init_count", 256'(init_count), 256'd0);
        checkOutput("mid_key_valid", 256'(dut.key_valid), 256'd0);
        reset = 1'b0;
        @(negedge clk);
        i0 = init_pulses;
        applyStimulus(0, 1'b1, 1'b0, KEY_A, PT);
        waitRsp(0, res);
        checkOutput("post_rst_result", 256'(res), 256'(CT));
        checkOutput("post_rst_init_pulse", 256'(init_pulses - i0), 256'd1);
        checkOutput("post_rst_init_count", 256'(init_count), 256'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
